// File: rtl/uart_rx_core.sv
// -----------------------------------------------------------------------------
// uart_rx_core
//
// UART receiver. Oversamples the serial line on glb_clk, validates the start
// bit, shifts in 8 data bits LSB first, then checks the optional parity bit and
// one or two stop bits. Each completed frame produces a one-cycle Rx_done_o
// pulse with its parity, framing and overrun status. The byte is written into
// the Rx FIFO with a single-cycle strobe unless the FIFO is full.
//
// Build option:
//   RX_MAJORITY_VOTE_EN  when defined, every bit (start included) is the
//                        2-of-3 majority of the synced samples at S-1, S, S+1
//                        around the nominal sample point S. The decision is
//                        taken at S+1. Needs CLKS_PER_BIT >= 6.
//
// Parameters:
//   CLKS_PER_BIT   glb_clk cycles per bit; even, >= 4
//   CNT_W          width of the bit-timing counter; must hold CLKS_PER_BIT-1
//
// Ports:
//   glb_clk        system clock
//   glb_rstn       asynchronous active-low reset
//   Rx_en_i        receiver enable; 0 aborts the frame and holds the FSM in IDLE
//   Stop_cfg_i     0 = one stop bit, 1 = two stop bits
//   Parity_cfg_i   00 none, 01 odd, 10 even, 11 none
//   Rx_bit_i       asynchronous serial line, idle high
//   FIFO_full_i    Rx FIFO full flag
//   Rx_data_o      last received byte, held until the next frame completes
//   FIFO_w_en_o    one-cycle FIFO write strobe
//   Rx_done_o      one-cycle pulse at every frame completion, written or dropped
//   Parity_err_o   parity error, valid while Rx_done_o=1
//   Frame_err_o    stop-bit error, valid while Rx_done_o=1
//   Overrun_err_o  byte dropped because the FIFO was full, valid while Rx_done_o=1
//   Rx_busy_o      high in any state other than IDLE
// -----------------------------------------------------------------------------
module uart_rx_core #(
    parameter int CLKS_PER_BIT = 8,
    parameter int CNT_W        = 8
) (
    input  logic       glb_clk,
    input  logic       glb_rstn,
    input  logic       Rx_en_i,
    input  logic       Stop_cfg_i,
    input  logic [1:0] Parity_cfg_i,
    input  logic       Rx_bit_i,
    input  logic       FIFO_full_i,
    output logic [7:0] Rx_data_o,
    output logic       FIFO_w_en_o,
    output logic       Rx_done_o,
    output logic       Parity_err_o,
    output logic       Frame_err_o,
    output logic       Overrun_err_o,
    output logic       Rx_busy_o
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP1,
        S_STOP2,
        S_DONE
    } state_e;

    // Count value at which a data/parity/stop bit is decided.
    localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(CLKS_PER_BIT - 1);

`ifdef RX_MAJORITY_VOTE_EN
    // Start bit is decided one cycle after its nominal midpoint so the third
    // vote sample is available. Counting restarts from that decision, which
    // keeps every later decision exactly one bit period apart.
    localparam logic [CNT_W-1:0] START_LAST = CNT_W'(CLKS_PER_BIT / 2);
`else
    localparam logic [CNT_W-1:0] START_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
`endif

    // ------------------------------------------------------------------
    // Input synchronizer and falling-edge detector
    // ------------------------------------------------------------------
    logic sync1_q;
    logic sync2_q;
    logic prev_q;
    logic fall_edge;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of its neighbour; blocking here would
    // collapse the synchronizer chain into a single stage.
    always_ff @(posedge glb_clk or negedge glb_rstn) begin
        if (!glb_rstn) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            prev_q  <= 1'b1;
        end else begin
            sync1_q <= Rx_bit_i;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
        end
    end

    assign fall_edge = prev_q & ~sync2_q;

    // ------------------------------------------------------------------
    // Bit value presented to the FSM at a decision point
    // ------------------------------------------------------------------
    logic bit_val;

`ifdef RX_MAJORITY_VOTE_EN
    // hist_q[0] / hist_q[1] hold the synced line one and two cycles ago, so at
    // a decision point the three votes are the samples at cnt-2, cnt-1, cnt.
    logic [1:0] hist_q;

    always_ff @(posedge glb_clk or negedge glb_rstn) begin
        if (!glb_rstn) begin
            hist_q <= 2'b11;
        end else begin
            hist_q <= {hist_q[0], sync2_q};
        end
    end

    assign bit_val = (hist_q[1] & hist_q[0]) |
                     (hist_q[1] & sync2_q)   |
                     (hist_q[0] & sync2_q);
`else
    assign bit_val = sync2_q;
`endif

    // ------------------------------------------------------------------
    // FSM and datapath registers
    // ------------------------------------------------------------------
    state_e           state_q,    state_d;
    logic [CNT_W-1:0] cnt_q,      cnt_d;
    logic [2:0]       idx_q,      idx_d;
    logic [7:0]       shift_q,    shift_d;
    logic [7:0]       data_q,     data_d;
    logic             par_err_q,  par_err_d;
    logic             frm_err_q,  frm_err_d;
    logic             stop2_q,    stop2_d;
    logic [1:0]       par_cfg_q,  par_cfg_d;

    logic bit_tick;
    logic parity_on;
    logic exp_parity;

    assign bit_tick   = (cnt_q == BIT_LAST);
    assign parity_on  = (par_cfg_q == 2'b01) || (par_cfg_q == 2'b10);
    // Even parity: the parity bit equals the XOR of the data; odd: its inverse.
    assign exp_parity = (par_cfg_q == 2'b10) ? (^shift_q) : ~(^shift_q);

    always_ff @(posedge glb_clk or negedge glb_rstn) begin
        if (!glb_rstn) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            idx_q     <= '0;
            shift_q   <= '0;
            data_q    <= '0;
            par_err_q <= 1'b0;
            frm_err_q <= 1'b0;
            stop2_q   <= 1'b0;
            par_cfg_q <= 2'b00;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            shift_q   <= shift_d;
            data_q    <= data_d;
            par_err_q <= par_err_d;
            frm_err_q <= frm_err_d;
            stop2_q   <= stop2_d;
            par_cfg_q <= par_cfg_d;
        end
    end

    always_comb begin
        // NOTE: every signal assigned in this block gets a default first, so
        // no path through the case statement can leave one unassigned and
        // infer a latch.
        state_d   = state_q;
        cnt_d     = cnt_q + 1'b1;
        idx_d     = idx_q;
        shift_d   = shift_q;
        data_d    = data_q;
        par_err_d = par_err_q;
        frm_err_d = frm_err_q;
        stop2_d   = stop2_q;
        par_cfg_d = par_cfg_q;

        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (Rx_en_i && fall_edge) begin
                    state_d   = S_START;
                    par_err_d = 1'b0;
                    frm_err_d = 1'b0;
                end
            end

            S_START: begin
                if (cnt_q == START_LAST) begin
                    cnt_d = '0;
                    if (bit_val) begin
                        // Line back high at mid start bit: glitch, not a frame.
                        state_d = S_IDLE;
                    end else begin
                        state_d   = S_DATA;
                        idx_d     = '0;
                        // Frame format is frozen here for the rest of the frame.
                        stop2_d   = Stop_cfg_i;
                        par_cfg_d = Parity_cfg_i;
                    end
                end
            end

            S_DATA: begin
                if (bit_tick) begin
                    cnt_d          = '0;
                    shift_d[idx_q] = bit_val;
                    idx_d          = idx_q + 3'd1;
                    if (idx_q == 3'd7) begin
                        state_d = parity_on ? S_PARITY : S_STOP1;
                    end
                end
            end

            S_PARITY: begin
                if (bit_tick) begin
                    cnt_d = '0;
                    if (bit_val != exp_parity) begin
                        par_err_d = 1'b1;
                    end
                    state_d = S_STOP1;
                end
            end

            S_STOP1: begin
                if (bit_tick) begin
                    cnt_d = '0;
                    if (!bit_val) begin
                        frm_err_d = 1'b1;
                    end
                    if (stop2_q) begin
                        state_d = S_STOP2;
                    end else begin
                        state_d = S_DONE;
                        data_d  = shift_q;
                    end
                end
            end

            S_STOP2: begin
                if (bit_tick) begin
                    cnt_d = '0;
                    if (!bit_val) begin
                        frm_err_d = 1'b1;
                    end
                    state_d = S_DONE;
                    data_d  = shift_q;
                end
            end

            S_DONE: begin
                cnt_d   = '0;
                state_d = S_IDLE;
            end

            default: begin
                cnt_d   = '0;
                state_d = S_IDLE;
            end
        endcase

        // Disable wins over everything: abandon the frame, keep the last
        // delivered byte, and forget any error collected so far.
        if (!Rx_en_i) begin
            state_d   = S_IDLE;
            cnt_d     = '0;
            data_d    = data_q;
            par_err_d = 1'b0;
            frm_err_d = 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    logic done_w;

    // Gated by Rx_en_i so a disable arriving in DONE suppresses the strobe.
    assign done_w        = (state_q == S_DONE) && Rx_en_i;

    assign Rx_done_o     = done_w;
    assign FIFO_w_en_o   = done_w & ~FIFO_full_i;
    assign Overrun_err_o = done_w &  FIFO_full_i;
    assign Parity_err_o  = done_w &  par_err_q;
    assign Frame_err_o   = done_w &  frm_err_q;
    assign Rx_data_o     = data_q;
    assign Rx_busy_o     = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_rx_core.sv
// -----------------------------------------------------------------------------
// tb_uart_rx_core
//
// Self-checking bench for uart_rx_core. A directed table of frames covers the
// listed corner cases; hand-written sequences cover false starts, disable
// mid-frame and asynchronous reset; randomized frames are checked against a
// frame-level reference model.
// -----------------------------------------------------------------------------
module tb_uart_rx_core;

    localparam int CPB = 8;

    logic       glb_clk;
    logic       glb_rstn;
    logic       Rx_en_i;
    logic       Stop_cfg_i;
    logic [1:0] Parity_cfg_i;
    logic       Rx_bit_i;
    logic       FIFO_full_i;
    logic [7:0] Rx_data_o;
    logic       FIFO_w_en_o;
    logic       Rx_done_o;
    logic       Parity_err_o;
    logic       Frame_err_o;
    logic       Overrun_err_o;
    logic       Rx_busy_o;

    uart_rx_core #(
        .CLKS_PER_BIT (CPB),
        .CNT_W        (8)
    ) dut (
        .glb_clk       (glb_clk),
        .glb_rstn      (glb_rstn),
        .Rx_en_i       (Rx_en_i),
        .Stop_cfg_i    (Stop_cfg_i),
        .Parity_cfg_i  (Parity_cfg_i),
        .Rx_bit_i      (Rx_bit_i),
        .FIFO_full_i   (FIFO_full_i),
        .Rx_data_o     (Rx_data_o),
        .FIFO_w_en_o   (FIFO_w_en_o),
        .Rx_done_o     (Rx_done_o),
        .Parity_err_o  (Parity_err_o),
        .Frame_err_o   (Frame_err_o),
        .Overrun_err_o (Overrun_err_o),
        .Rx_busy_o     (Rx_busy_o)
    );

    initial glb_clk = 1'b0;
    always #5 glb_clk = ~glb_clk;

    // Observed frame completion
    typedef struct packed {
        logic [7:0] data;
        logic       wen;
        logic       perr;
        logic       ferr;
        logic       ovr;
    } obs_t;

    // Directed vector: frame stimulus plus hand-derived expectation
    typedef struct {
        logic [7:0] data;
        logic [1:0] pcfg;
        logic       scfg;
        logic       flip;
        logic       s1;
        logic       s2;
        logic       full;
        int         gap;
        obs_t       exp;
    } vec_t;

    int   n_checks  = 0;
    int   n_errors  = 0;
    int   done_count = 0;
    int   wen_count  = 0;
    int   exp_done   = 0;
    int   exp_wen    = 0;
    obs_t obs_q[$];

    always @(negedge glb_clk) begin
        if (glb_rstn && Rx_done_o) begin
            obs_q.push_back({Rx_data_o, FIFO_w_en_o, Parity_err_o, Frame_err_o, Overrun_err_o});
            done_count++;
        end
        if (glb_rstn && FIFO_w_en_o) begin
            wen_count++;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", n_errors, n_checks);
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive_bit(input logic b);
        Rx_bit_i = b;
        repeat (CPB) @(negedge glb_clk);
    endtask

    task automatic idle_bits(input int n);
        Rx_bit_i = 1'b1;
        repeat (n * CPB) @(negedge glb_clk);
    endtask

    // Sends one frame. The configuration inputs are scrambled right after the
    // start bit; the receiver must keep using the values present at start.
    task automatic send_frame(input logic [7:0] d, input logic [1:0] pcfg, input logic scfg,
                              input logic flip, input logic s1, input logic s2);
        logic pbit;
        Parity_cfg_i = pcfg;
        Stop_cfg_i   = scfg;
        drive_bit(1'b0);
        Parity_cfg_i = 2'($urandom);
        Stop_cfg_i   = 1'($urandom);
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
        if (pcfg == 2'b01 || pcfg == 2'b10) begin
            pbit = (pcfg == 2'b10) ? (^d) : ~(^d);
            drive_bit(pbit ^ flip);
        end
        drive_bit(s1);
        if (scfg) drive_bit(s2);
    endtask

    // Reference model: the frame outcome follows from what was put on the line.
    function automatic obs_t model(input logic [7:0] d, input logic [1:0] pcfg, input logic scfg,
                                   input logic flip, input logic s1, input logic s2, input logic full);
        obs_t r;
        r.data = d;
        r.perr = ((pcfg == 2'b01) || (pcfg == 2'b10)) && flip;
        r.ferr = !s1 || (scfg && !s2);
        r.ovr  = full;
        r.wen  = !full;
        return r;
    endfunction

    task automatic expect_frame(input string tag, input obs_t e);
        int   waited;
        obs_t o;
        waited = 0;
        while (obs_q.size() == 0 && waited < 4 * CPB) begin
            @(negedge glb_clk);
            waited++;
        end
        check({tag, "_seen"}, 32'(obs_q.size() != 0), 32'd1);
        if (obs_q.size() != 0) begin
            o = obs_q.pop_front();
            check({tag, "_data"}, 32'(o.data), 32'(e.data));
            check({tag, "_wen"},  32'(o.wen),  32'(e.wen));
            check({tag, "_perr"}, 32'(o.perr), 32'(e.perr));
            check({tag, "_ferr"}, 32'(o.ferr), 32'(e.ferr));
            check({tag, "_ovr"},  32'(o.ovr),  32'(e.ovr));
        end
        exp_done++;
        exp_wen += int'(e.wen);
    endtask

    vec_t vecs[11];

    initial begin
        int   cycles;
        logic saw_busy;
        logic [7:0] last_data;

        //                data   pcfg   scfg  flip  s1    s2    full  gap  {data, wen, perr, ferr, ovr}
        vecs[0]  = '{8'hA5, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 2, '{8'hA5, 1'b1, 1'b0, 1'b0, 1'b0}};
        vecs[1]  = '{8'hDE, 2'b01, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 2, '{8'hDE, 1'b1, 1'b0, 1'b0, 1'b0}};
        vecs[2]  = '{8'hDE, 2'b01, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 2, '{8'hDE, 1'b1, 1'b1, 1'b0, 1'b0}};
        vecs[3]  = '{8'h3C, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2, '{8'h3C, 1'b1, 1'b0, 1'b1, 1'b0}};
        vecs[4]  = '{8'h55, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 2, '{8'h55, 1'b1, 1'b0, 1'b0, 1'b0}};
        vecs[5]  = '{8'h81, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 2, '{8'h81, 1'b0, 1'b0, 1'b0, 1'b1}};
        vecs[6]  = '{8'h0F, 2'b11, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 2, '{8'h0F, 1'b1, 1'b0, 1'b1, 1'b0}};
        vecs[7]  = '{8'hDE, 2'b10, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 0, '{8'hDE, 1'b1, 1'b0, 1'b0, 1'b0}};
        vecs[8]  = '{8'hDF, 2'b10, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 0, '{8'hDF, 1'b1, 1'b0, 1'b0, 1'b0}};
        vecs[9]  = '{8'hE0, 2'b10, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 0, '{8'hE0, 1'b1, 1'b0, 1'b0, 1'b0}};
        vecs[10] = '{8'hE1, 2'b10, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 0, '{8'hE1, 1'b1, 1'b0, 1'b0, 1'b0}};

        glb_rstn     = 1'b0;
        Rx_en_i      = 1'b1;
        Stop_cfg_i   = 1'b0;
        Parity_cfg_i = 2'b00;
        Rx_bit_i     = 1'b1;
        FIFO_full_i  = 1'b0;
        repeat (3) @(negedge glb_clk);

        // Reset state
        check("rst_data", 32'(Rx_data_o), 32'h0);
        check("rst_wen",  32'(FIFO_w_en_o), 32'h0);
        check("rst_done", 32'(Rx_done_o), 32'h0);
        check("rst_busy", 32'(Rx_busy_o), 32'h0);
        check("rst_errs", 32'({Parity_err_o, Frame_err_o, Overrun_err_o}), 32'h0);
        glb_rstn = 1'b1;
        idle_bits(1);

        // Directed table
        for (int i = 0; i < 11; i++) begin
            FIFO_full_i = vecs[i].full;
            send_frame(vecs[i].data, vecs[i].pcfg, vecs[i].scfg, vecs[i].flip, vecs[i].s1, vecs[i].s2);
            expect_frame($sformatf("vec%0d", i), vecs[i].exp);
            FIFO_full_i = 1'b0;
            if (vecs[i].gap > 0) idle_bits(vecs[i].gap);
            if (i == 0) check("vec0_busy_after_done", 32'(Rx_busy_o), 32'h0);
        end

        // Fifth back-to-back frame aborted by disable during data bits
        Parity_cfg_i = 2'b10;
        Stop_cfg_i   = 1'b0;
        drive_bit(1'b0);
        drive_bit(1'b1);
        drive_bit(1'b0);
        drive_bit(1'b1);
        check("abort_busy_before", 32'(Rx_busy_o), 32'h1);
        Rx_en_i = 1'b0;
        @(negedge glb_clk);
        check("abort_busy_after", 32'(Rx_busy_o), 32'h0);
        idle_bits(3);
        check("abort_no_done", 32'(done_count), 32'(exp_done));
        check("abort_no_write", 32'(wen_count), 32'(exp_wen));
        check("abort_data_held", 32'(Rx_data_o), 32'hE1);
        Rx_en_i = 1'b1;
        idle_bits(1);

        // False start: line low for two clocks only
        Rx_bit_i = 1'b0;
        repeat (2) @(negedge glb_clk);
        Rx_bit_i = 1'b1;
        cycles   = 0;
        saw_busy = 1'b0;
        while (cycles < 4 * CPB && !(saw_busy && !Rx_busy_o)) begin
            @(negedge glb_clk);
            cycles++;
            if (Rx_busy_o) saw_busy = 1'b1;
        end
        check("false_start_entered", 32'(saw_busy), 32'h1);
        check("false_start_idle_in_time", 32'(cycles <= CPB / 2 + 3), 32'h1);
        idle_bits(2);
        check("false_start_no_done", 32'(done_count), 32'(exp_done));

        // Randomized frames against the reference model
        last_data = 8'hE1;
        for (int i = 0; i < 24; i++) begin
            logic [7:0] d;
            logic [1:0] pcfg;
            logic       scfg, flip, s1, s2, full;
            d    = 8'($urandom);
            pcfg = 2'($urandom);
            scfg = 1'($urandom);
            flip = ($urandom_range(0, 3) == 0);
            s1   = ($urandom_range(0, 4) != 0);
            s2   = ($urandom_range(0, 4) != 0);
            full = ($urandom_range(0, 4) == 0);
            FIFO_full_i = full;
            send_frame(d, pcfg, scfg, flip, s1, s2);
            expect_frame($sformatf("rnd%0d", i), model(d, pcfg, scfg, flip, s1, s2, full));
            FIFO_full_i = 1'b0;
            last_data = d;
            idle_bits(int'($urandom_range(1, 2)));
        end
        check("total_done", 32'(done_count), 32'(exp_done));
        check("total_writes", 32'(wen_count), 32'(exp_wen));
        check("data_held_after_frames", 32'(Rx_data_o), 32'(last_data));

        // Asynchronous reset in the middle of a frame
        drive_bit(1'b0);
        Rx_bit_i = 1'b1;
        repeat (CPB / 2) @(negedge glb_clk);
        check("midframe_busy", 32'(Rx_busy_o), 32'h1);
        #2;
        glb_rstn = 1'b0;
        #1;
        check("async_rst_busy", 32'(Rx_busy_o), 32'h0);
        check("async_rst_data", 32'(Rx_data_o), 32'h0);
        @(negedge glb_clk);
        glb_rstn = 1'b1;
        idle_bits(2);
        check("post_rst_idle", 32'(Rx_busy_o), 32'h0);
        check("post_rst_no_done", 32'(done_count), 32'(exp_done));

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/uart_rx_core.md
Name: uart_rx_core

Overview:
UART receiver, the counterpart of the existing UART Tx path. Uses the same configuration: stop-bit select, 2-bit parity select, enable.
- Oversamples the serial line on glb_clk.
- Validates the start bit, shifts in 8 data bits LSB first, then checks parity and stop bit(s).
- Pushes each completed byte into the Rx FIFO through a single-cycle write strobe. Parity, framing and overrun status accompany each frame.

Parameters:
CLKS_PER_BIT, 8, glb_clk cycles per bit; even, >=4.
CNT_W, 8, width of the bit-timing counter; must hold CLKS_PER_BIT-1.

Ports:
glb_clk  input  1  system clock
glb_rstn  input  1  asynchronous active-low reset
Rx_en_i  input  1  receiver enable; 0 aborts and holds FSM in IDLE
Stop_cfg_i  input  1  0 = one stop bit, 1 = two stop bits
Parity_cfg_i  input  2  00 none, 01 odd, 10 even, 11 none
Rx_bit_i  input  1  asynchronous serial line, idle high
FIFO_full_i  input  1  Rx FIFO full flag
Rx_data_o  output  8  received byte, held until next frame completes
FIFO_w_en_o  output  1  one-cycle FIFO write strobe
Rx_done_o  output  1  one-cycle pulse at every frame completion, written or dropped
Parity_err_o  output  1  valid while Rx_done_o=1
Frame_err_o  output  1  valid while Rx_done_o=1
Overrun_err_o  output  1  valid while Rx_done_o=1
Rx_busy_o  output  1  high in any state other than IDLE

Behaviour:
Reset:
- All outputs 0, Rx_data_o=8'h00.
- Synchronizer flops reset to 1; FSM in IDLE.

Input sync and edge detect:
- Rx_bit_i passes through 2 flops; the second flop output is the synced bit.
- A third flop holds the previous synced value for falling-edge detection.

States: IDLE, START, DATA, PARITY, STOP1, STOP2, DONE.
- IDLE: on falling edge of the synced line with Rx_en_i=1, go to START with cnt=0.
- START: sample when cnt==CLKS_PER_BIT/2-1.
  - Sample 1 (false start): return to IDLE.
  - Sample 0: go to DATA, cnt=0, bit index=0.
- DATA, PARITY, STOP1, STOP2: each bit is sampled when cnt==CLKS_PER_BIT-1, then cnt resets to 0.
  - DATA: shift the sampled bit into bit[idx]. After idx 7, go to PARITY if parity is enabled, else STOP1.
- PARITY:
  - Expected bit = XOR(data) for even, ~XOR(data) for odd.
  - Mismatch latches a parity error. Then go to STOP1.
- STOP1: sample 0 latches a frame error. Go to STOP2 if Stop_cfg_i=1, else DONE.
- STOP2: sample 0 latches a frame error. Go to DONE.
- DONE (exactly one cycle, then IDLE):
  - Rx_done_o=1 and Rx_data_o updated.
  - Parity_err_o and Frame_err_o driven from the latched errors.
  - FIFO_full_i=0: FIFO_w_en_o=1 and Overrun_err_o=0. Bytes are written even with parity or frame errors.
  - FIFO_full_i=1: FIFO_w_en_o=0, Overrun_err_o=1, byte dropped; Rx_data_o still updates.

Other rules:
- Stop_cfg_i and Parity_cfg_i are sampled on leaving START and held for the frame; mid-frame changes are ignored.
- Rx_en_i=0 in any state: next cycle is IDLE. There is no write and no Rx_done_o; latched errors are cleared.
- Back-to-back frames: a start edge arriving while in DONE or STOP is caught from IDLE. The edge detector sees the history, so the next falling edge after the stop-bit sample midpoint is accepted.
- Latency: Rx_done_o asserts 2 sync cycles + CLKS_PER_BIT/2 + (N_bits-1)*CLKS_PER_BIT + 1 cycles after the line's falling edge, where N_bits counts start, data, parity and stop bits.
- Asynchronous reset mid-frame returns everything to reset values immediately.

Optional Feature:
RX_MAJORITY_VOTE_EN
- Defined: each bit value (start included) is the 2-of-3 majority of synced samples at cnt==S-1, S and S+1, where S is the nominal sample point. The decision and state transition occur at S+1, and all later sample points keep the original nominal spacing. Requires CLKS_PER_BIT>=6.
- Undefined: single sample at the nominal point.

Test Plan:
- CLKS_PER_BIT=8, no parity, 1 stop, send 0xA5 -> exactly one FIFO_w_en_o, Rx_data_o=0xA5, all error flags 0, Rx_busy_o low after DONE.
- Odd parity, 2 stop, send 0xDE with parity bit 1 -> written, Parity_err_o=0; repeat with parity bit 0 -> written, Parity_err_o=1.
- Send 0x3C with stop bit driven 0 -> Rx_done_o with Frame_err_o=1, byte 0x3C written; a following good frame 0x55 decodes cleanly.
- Line low for 2 clocks then high -> START rejects it, no Rx_done_o, Rx_busy_o returns 0 within CLKS_PER_BIT/2+3 cycles.
- FIFO_full_i=1 at DONE of frame 0x81 -> FIFO_w_en_o=0, Overrun_err_o=1, Rx_data_o=0x81.
- Four back-to-back frames 0xDE, 0xDF, 0xE0, 0xE1 (even parity, 1 stop) -> four writes in order, no errors. Then deassert Rx_en_i mid-data of a fifth frame -> no write, FSM IDLE next cycle.
